// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: size codes, FSM states, alignment helper.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_RDW  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Only the byte offset matters for alignment; range and illegal size are checked separately.
  function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] addr);
    return ((size == SZ_HALF) && addr[0]) || ((size == SZ_WORD) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: extracts a right-aligned load value from a RAM word and
// merges right-aligned store data into it. Purely combinational, no handshake.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [31:0] shifted;

  always_comb begin
    shifted  = word >> {offset, 3'b000};
    load_val = shifted;
    merged   = word;
    case (size)
      SZ_BYTE: begin
        load_val = {24'b0, shifted[7:0]};
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_val = {16'b0, shifted[15:0]};
        merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_val = shifted;
        merged   = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store engine in front of a 1-cycle-latency word RAM; sub-word stores use
// read-modify-write. Done after 1 (error), 2 (word store), 3 (load) or 4 (sub-word store) cycles.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [1:0]           size,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          rdata,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_we,
  output logic [31:0]          ram_wdata,
  input  logic [31:0]          ram_q
);

  state_t               state, state_nxt;
  logic [ADDR_BITS+1:0] lat_addr;
  logic [1:0]           lat_size;
  logic                 lat_we;
  logic [31:0]          lat_wdata;
  logic                 lat_err;

  logic                 req_err;
  logic                 word_store;
  logic [31:0]          load_val;
  logic [31:0]          merged;

  assign req_err = (size == SZ_ILLEGAL) || addr_misaligned(size, addr[1:0])
                   || (|addr[31:ADDR_BITS+2]);
  assign word_store = we && (size == SZ_WORD);
  assign ram_addr   = lat_addr[ADDR_BITS+1:2];

  mem_lane_align u_lane_align (
    .word     (ram_q),
    .offset   (lat_addr[1:0]),
    .size     (lat_size),
    .wdata    (lat_wdata),
    .load_val (load_val),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    ram_we    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (!req)           state_nxt = ST_IDLE;
        else if (req_err)   state_nxt = ST_DONE;
        else if (word_store) state_nxt = ST_WR;
        else                state_nxt = ST_RD;
      end
      ST_RD:   state_nxt = ST_RDW;
      ST_RDW:  state_nxt = lat_we ? ST_WR : ST_DONE;
      ST_WR: begin
        ram_we    = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        err       = lat_err;
        state_nxt = ST_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr  <= '0;
      lat_size  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lat_err   <= 1'b0;
      rdata     <= '0;
      ram_wdata <= '0;
    end else begin
      if (state == ST_IDLE && req) begin
        lat_addr  <= addr[ADDR_BITS+1:0];
        lat_size  <= size;
        lat_we    <= we;
        lat_wdata <= wdata;
        lat_err   <= req_err;
        // Word stores skip the read, so the write word is staged straight away.
        if (!req_err && word_store) ram_wdata <= wdata;
      end
      if (state == ST_RDW) begin
        if (lat_we) ram_wdata <= merged;
        else        rdata     <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised scoreboard bench for mem_access_unit against a byte-array reference memory.
module tb_mem_access_unit;

  localparam int AB        = 12;
  localparam int WORDS     = 1 << AB;
  localparam int MEM_BYTES = 4 * WORDS;

  logic          clk = 1'b0;
  logic          rst;
  logic          req, we;
  logic [1:0]    size;
  logic [31:0]   addr, wdata;
  logic          busy, done, err;
  logic [31:0]   rdata;
  logic [AB-1:0] ram_addr;
  logic          ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_q;

  mem_access_unit #(.ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Synchronous RAM with 1-cycle read latency, filled on its first clock edge.
  logic [31:0] ram [WORDS];
  bit          ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int w = 0; w < WORDS; w++) ram[w] <= init_word(w);
      ram_ready <= 1'b1;
    end else begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_q <= ram[ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          done_cyc;
    bit          wr;
    logic [AB-1:0] waddr;
    logic [31:0] wword;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] model_rdata;

  // Reference: byte-addressed memory, errors and latency straight from the access rules.
  task automatic drive_push(input bit w, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] d);
    exp_t e;
    int   nb;
    int   lat;
    bit   bad;
    logic [31:0] v;
    nb  = 1 << sz;
    bad = (sz == 2'd3) || ((a % nb) != 0) || (a >= 32'(MEM_BYTES));
    lat = bad ? 1 : (w && sz == 2'd2) ? 2 : !w ? 3 : 4;
    e.err = bad;
    e.wr = 1'b0;
    e.waddr = '0;
    e.wword = '0;
    if (!bad && !w) begin
      v = '0;
      for (int i = 0; i < nb; i++) v |= 32'(ref_mem[a + i]) << (8 * i);
      model_rdata = v;
    end
    if (!bad && w) begin
      for (int i = 0; i < nb; i++) ref_mem[a + i] = d[8*i +: 8];
      e.wr = 1'b1;
      e.waddr = a[AB+1:2];
      for (int i = 0; i < 4; i++) e.wword[8*i +: 8] = ref_mem[{a[31:2], 2'b00} + i];
    end
    e.rdata = model_rdata;
    e.done_cyc = cyc + lat;
    sb.push_back(e);
    req = 1'b1; we = w; size = sz; addr = a; wdata = d;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      chk("done_timeout", 32'(done), 32'd1);
      sb.delete();
    end
  endtask

  task automatic run_txn(input bit w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d);
    @(negedge clk);
    drive_push(w, sz, a, d);
    @(negedge clk);
    req = 1'b0;
    wait_done();
  endtask

  // Monitor: checks every RAM write and every done pulse against the front of the scoreboard.
  int seen_wr = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      seen_wr = 0;
    end else begin
      if (ram_we) begin
        if (sb.size() == 0 || !sb[0].wr) begin
          chk("ram_we_unexpected", 32'(ram_we), 32'd0);
        end else begin
          seen_wr++;
          chk("ram_addr", 32'(ram_addr), 32'(sb[0].waddr));
          chk("ram_wdata", ram_wdata, sb[0].wword);
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("err", 32'(err), 32'(e.err));
          chk("rdata", rdata, e.rdata);
          chk("latency_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("write_count", 32'(seen_wr), 32'(e.wr));
        end
        seen_wr = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    for (int w = 0; w < WORDS; w++)
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = 8'(init_word(w) >> (8 * b));
    model_rdata = '0;
    rst = 1'b0; req = 1'b0; we = 1'b0; size = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    rst = 1'b1;

    // Word store then load.
    run_txn(1, 2'd2, 32'h10, 32'hDEADBEEF);
    run_txn(0, 2'd2, 32'h10, 32'h0);
    chk("word_load_value", rdata, 32'hDEADBEEF);

    // Byte read-modify-write and byte load.
    run_txn(1, 2'd2, 32'h10, 32'h11223344);
    run_txn(1, 2'd0, 32'h12, 32'h000000AA);
    chk("byte_rmw_ram", ram[4], 32'h11AA3344);
    run_txn(0, 2'd0, 32'h13, 32'h0);
    chk("byte_load_value", rdata, 32'h00000011);

    // Half load and half store.
    run_txn(0, 2'd1, 32'h12, 32'h0);
    chk("half_load_value", rdata, 32'h000011AA);
    run_txn(1, 2'd1, 32'h10, 32'h0000BEEF);
    run_txn(0, 2'd2, 32'h10, 32'h0);
    chk("half_store_word", rdata, 32'h11AABEEF);

    // Error cases.
    run_txn(0, 2'd1, 32'h11, 32'h0);
    run_txn(1, 2'd2, 32'h12, 32'h12345678);
    run_txn(1, 2'd3, 32'h10, 32'h12345678);
    run_txn(1, 2'd2, 32'h4000, 32'h12345678);
    chk("err_rdata_held", rdata, 32'h11AABEEF);

    // req pulsed while busy must be ignored.
    @(negedge clk);
    drive_push(0, 2'd2, 32'h10, 32'h0);
    @(negedge clk);
    chk("busy_in_rd", 32'(busy), 1);
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'hCAFEF00D;
    @(negedge clk);
    req = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    chk("ignored_req_no_done", 32'(sb.size()), 0);

    // req held high: back-to-back word stores every 3 cycles.
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      drive_push(1, 2'd2, 32'h40 + 32'(4 * k), $urandom);
      chk("b2b_busy_idle", 32'(busy), 0);
      @(negedge clk);
      chk("b2b_busy_wr", 32'(busy), 1);
      @(negedge clk);
      chk("b2b_busy_done", 32'(busy), 1);
      chk("b2b_done", 32'(done), 1);
      @(negedge clk);
    end
    req = 1'b0;

    // Reset during RDW of a byte store aborts it.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd0; addr = 32'h11; wdata = 32'h55;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_ram_we", 32'(ram_we), 0);
    chk("midrst_ram_wdata", ram_wdata, 0);
    chk("midrst_ram_addr", 32'(ram_addr), 0);
    model_rdata = '0;
    @(negedge clk);
    rst = 1'b1;
    run_txn(0, 2'd2, 32'h10, 32'h0);
    chk("midrst_word_kept", rdata, 32'h11AABEEF);
    run_txn(1, 2'd0, 32'h11, 32'h55);
    run_txn(0, 2'd2, 32'h10, 32'h0);
    chk("post_rst_store", rdata, 32'h11AA55EF);

    // Random traffic in a small window, with occasional illegal sizes and far addresses.
    for (int t = 0; t < 300; t++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
      run_txn(1'($urandom_range(0, 1)), sz, a, $urandom);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
